// File: rtl/sat_adder_array_seq_pkg.sv
// rtl/sat_adder_array_seq_pkg.sv - node indices and configuration chain layout helpers
package sat_pkg;

    localparam int NODE_P = 0;
    localparam int NODE_G = 1;
    localparam int NODE_S = 2;
    localparam int NODE_C = 3;
    localparam int NODES  = 4;

    // Select field (shared by all lanes) followed by per-lane value field
    function automatic int cfg_width(input int lanes, input int width);
        return NODES * width + NODES * lanes * width;
    endfunction

    function automatic int sel_idx(input int k, input int n);
        return NODES * k + n;
    endfunction

    function automatic int val_idx(input int width, input int l, input int k, input int n);
        return NODES * width + NODES * (l * width + k) + n;
    endfunction

endpackage

// File: rtl/sat_adder_array_seq_if.sv
// rtl/sat_adder_array_seq_if.sv - operand/result valid-ready bus of the adder array
interface sat_adder_array_seq_if #(
    parameter int LANES = 3,
    parameter int WIDTH = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   a;
    logic [LANES*WIDTH-1:0]   b;
    logic [LANES-1:0]         cin;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   sum;
    logic [LANES-1:0]         cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/sat_adder_array_seq_bit_cell.sv
// rtl/sat_adder_array_seq_bit_cell.sv - single full-adder bit with per-node force overrides
module sat_bit_cell
    import sat_pkg::*;
(
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic [NODES-1:0] sel,
    input  logic [NODES-1:0] val,
    output logic             s,
    output logic             c,
    output logic [NODES-1:0] raw
);

    logic p_raw;
    logic g_raw;
    logic s_raw;
    logic c_raw;
    logic p;
    logic g;

    assign p_raw = a ^ b;
    assign g_raw = a & b;
    assign p     = sel[NODE_P] ? val[NODE_P] : p_raw;
    assign g     = sel[NODE_G] ? val[NODE_G] : g_raw;

    // Downstream nodes see forced upstream values; raw is each node before its own force
    assign s_raw = p ^ cin;
    assign c_raw = g | (p & cin);
    assign s     = sel[NODE_S] ? val[NODE_S] : s_raw;
    assign c     = sel[NODE_C] ? val[NODE_C] : c_raw;

    always_comb begin
        raw         = '0;
        raw[NODE_P] = p_raw;
        raw[NODE_G] = g_raw;
        raw[NODE_S] = s_raw;
        raw[NODE_C] = c_raw;
    end

endmodule

// File: rtl/sat_adder_array_seq.sv
// rtl/sat_adder_array_seq.sv - LANES x WIDTH fault-injectable ripple adder array with registered output
module sat_adder_array_seq
    import sat_pkg::*;
#(
    parameter int LANES = 3,
    parameter int WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sat_adder_array_seq_if.slave  bus,
    input  logic                  cfg_en,
    input  logic                  cfg_si,
    output logic                  cfg_so,
    input  logic                  cfg_commit,
    input  logic                  cfg_capture
);

    localparam int CFG_W = cfg_width(LANES, WIDTH);
    localparam int SEL_W = NODES * WIDTH;
    localparam int CAP_W = NODES * LANES * WIDTH;

    logic [CFG_W-1:0]       shadow;
    logic [CFG_W-1:0]       active;
    logic [CAP_W-1:0]       cap_q;
    logic [CAP_W-1:0]       raw_nodes;
    logic [LANES*WIDTH-1:0] sum_d;
    logic [LANES*WIDTH-1:0] sum_q;
    logic [LANES-1:0]       cout_d;
    logic [LANES-1:0]       cout_q;
    logic                   out_valid_q;
    logic                   ready;
    logic                   accept;

    assign ready         = !out_valid_q | bus.out_ready;
    assign accept        = bus.in_valid & ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign cfg_so        = shadow[0];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH:0] carry;

        assign carry[0] = bus.cin[l];

        for (genvar k = 0; k < WIDTH; k++) begin : g_bit
            logic [NODES-1:0] sel_k;
            logic [NODES-1:0] val_k;

            assign sel_k = active[sel_idx(k, 0) +: NODES];
            assign val_k = active[val_idx(WIDTH, l, k, 0) +: NODES];

            sat_bit_cell u_cell (
                .a   (bus.a[l*WIDTH+k]),
                .b   (bus.b[l*WIDTH+k]),
                .cin (carry[k]),
                .sel (sel_k),
                .val (val_k),
                .s   (sum_d[l*WIDTH+k]),
                .c   (carry[k+1]),
                .raw (raw_nodes[(l*WIDTH+k)*NODES +: NODES])
            );
        end

        assign cout_d[l] = carry[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= '0;
            cap_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            cap_q       <= raw_nodes;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Capture pre-empts commit and shift; commit and shift may share an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else if (cfg_capture) begin
            shadow <= {cap_q, active[SEL_W-1:0]};
        end else begin
            if (cfg_commit) begin
                active <= shadow;
            end
            if (cfg_en) begin
                shadow <= {cfg_si, shadow[CFG_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_sat_adder_array_seq.sv
// tb/tb_sat_adder_array_seq.sv - self-checking bench for sat_adder_array_seq
module tb_sat_adder_array_seq;

    localparam int L  = 3;
    localparam int W  = 3;
    localparam int CW = 4 * W + 4 * L * W;

    logic clk;
    logic rst_n;
    logic cfg_en;
    logic cfg_si;
    logic cfg_so;
    logic cfg_commit;
    logic cfg_capture;

    sat_adder_array_seq_if #(.LANES(L), .WIDTH(W)) bus ();

    sat_adder_array_seq #(.LANES(L), .WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cfg_en      (cfg_en),
        .cfg_si      (cfg_si),
        .cfg_so      (cfg_so),
        .cfg_commit  (cfg_commit),
        .cfg_capture (cfg_capture)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit          sh_q[$];
    logic [CW-1:0] act_m;
    logic        m_valid;
    logic [8:0]  m_sum;
    logic [2:0]  m_cout;
    logic [35:0] m_cap;
    bit          got[CW];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        sh_q.delete();
        for (int i = 0; i < CW; i++) sh_q.push_back(1'b0);
        act_m   = '0;
        m_valid = 1'b0;
        m_sum   = '0;
        m_cout  = '0;
        m_cap   = '0;
    endtask

    // Bit-by-bit ripple evaluation following the node rules: each node forced when its select is set
    task automatic model_eval(input logic [8:0] av, input logic [8:0] bv, input logic [2:0] cv,
                              input logic [CW-1:0] act,
                              output logic [8:0] s, output logic [2:0] co, output logic [35:0] raw);
        s = '0; co = '0; raw = '0;
        for (int l = 0; l < L; l++) begin
            logic carry;
            carry = cv[l];
            for (int k = 0; k < W; k++) begin
                logic [3:0] node;
                logic [3:0] frc;
                int vb;
                vb = 4 * W + 4 * (l * W + k);
                node[0] = av[l*W+k] ^ bv[l*W+k];
                node[1] = av[l*W+k] & bv[l*W+k];
                frc[0]  = act[4*k+0] ? act[vb+0] : node[0];
                frc[1]  = act[4*k+1] ? act[vb+1] : node[1];
                node[2] = frc[0] ^ carry;
                node[3] = frc[1] | (frc[0] & carry);
                frc[2]  = act[4*k+2] ? act[vb+2] : node[2];
                frc[3]  = act[4*k+3] ? act[vb+3] : node[3];
                s[l*W+k] = frc[2];
                carry    = frc[3];
                raw[4*(l*W+k) +: 4] = node;
            end
            co[l] = carry;
        end
    endtask

    // One clock edge: predict, advance, then check every observable output
    task automatic cycle();
        bit exp_rdy, acc;
        logic [8:0]  ns;
        logic [2:0]  nc;
        logic [35:0] nr;
        exp_rdy = !m_valid || bus.out_ready;
        acc     = bus.in_valid && exp_rdy;
        model_eval(bus.a, bus.b, bus.cin, act_m, ns, nc, nr);
        if (cfg_capture) begin
            sh_q.delete();
            for (int i = 0; i < 4 * W; i++) sh_q.push_back(act_m[i]);
            for (int i = 0; i < 4 * L * W; i++) sh_q.push_back(m_cap[i]);
        end else begin
            if (cfg_commit) for (int i = 0; i < CW; i++) act_m[i] = sh_q[i];
            if (cfg_en) begin
                void'(sh_q.pop_front());
                sh_q.push_back(cfg_si);
            end
        end
        if (acc) begin
            m_valid = 1'b1; m_sum = ns; m_cout = nc; m_cap = nr;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("sum", bus.sum, m_sum);
        chk("cout", bus.cout, m_cout);
        chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
        chk("cfg_so", cfg_so, sh_q[0]);
    endtask

    task automatic idle();
        bus.in_valid = 0; cfg_en = 0; cfg_commit = 0; cfg_capture = 0; cfg_si = 0;
    endtask

    task automatic beat(input logic [8:0] av, input logic [8:0] bv, input logic [2:0] cv);
        bus.in_valid = 1; bus.out_ready = 1; bus.a = av; bus.b = bv; bus.cin = cv;
        cycle();
        bus.in_valid = 0;
    endtask

    // Bit 0 of the vector enters first, so after CW shifts it lands in shadow[0]
    task automatic shift_vec(input logic [CW-1:0] v);
        for (int i = 0; i < CW; i++) begin
            cfg_en = 1; cfg_si = v[i];
            cycle();
        end
        cfg_en = 0; cfg_si = 0;
    endtask

    task automatic commit();
        cfg_commit = 1;
        cycle();
        cfg_commit = 0;
    endtask

    initial begin
        logic [CW-1:0] v;
        logic [2:0] fp, fg, fs, fc;

        rst_n = 0; idle();
        bus.out_ready = 1; bus.a = 0; bus.b = 0; bus.cin = 0;
        mreset();
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_cfg_so", cfg_so, 0);
        @(posedge clk); #1; rst_n = 1;

        // Plain beat: lanes (3+5+0), (2+1+1), (7+7+1)
        beat(9'b111_010_011, 9'b111_001_101, 3'b110);
        chk("beat1_sum", bus.sum, 9'b111_100_000);
        chk("beat1_cout", bus.cout, 3'b101);
        cycle();

        // Backpressure
        bus.in_valid = 1; bus.out_ready = 1; bus.a = 9'h0ff; bus.b = 9'h011; bus.cin = 3'b001;
        cycle();
        bus.out_ready = 0; bus.a = 9'h123; bus.b = 9'h045;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1;
        cycle();
        bus.in_valid = 0;
        cycle();

        // Sum force on lane0 bit0
        v = '0; v[2] = 1'b1; v[4*W + 2] = 1'b1;
        shift_vec(v);
        beat(9'h000, 9'h000, 3'b000);
        chk("pre_commit_sum", bus.sum, 9'h000);
        bus.in_valid = 1; bus.a = 0; bus.b = 0; bus.cin = 0;
        commit();
        chk("commit_edge_sum", bus.sum, 9'h000);
        beat(9'h000, 9'h000, 3'b000);
        chk("sum_force", bus.sum, 9'h001);

        // Carry force: lane1 bit0 C=1, lane2 bit2 C=1
        v = '0; v[3] = 1'b1; v[11] = 1'b1; v[4*W + 4*(1*W+0) + 3] = 1'b1; v[4*W + 4*(2*W+2) + 3] = 1'b1;
        shift_vec(v);
        commit();
        beat(9'b000_000_000, 9'b000_010_000, 3'b000);
        chk("cfrc_sum", bus.sum, 9'b000_100_000);
        chk("cfrc_cout", bus.cout, 3'b100);

        // Clear overrides; last shift shares its edge with a commit
        for (int i = 0; i < CW - 1; i++) begin
            cfg_en = 1; cfg_si = 0; cycle();
        end
        cfg_commit = 1; cycle();
        idle();
        commit();

        // Capture of lane0 6+3
        beat(9'h006, 9'h003, 3'b000);
        cfg_capture = 1; cycle(); cfg_capture = 0;
        for (int i = 0; i < CW; i++) begin
            got[i] = cfg_so;
            cfg_en = 1; cfg_si = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        for (int k = 0; k < W; k++) begin
            fp[k] = got[4*W + 4*k + 0];
            fg[k] = got[4*W + 4*k + 1];
            fs[k] = got[4*W + 4*k + 2];
            fc[k] = got[4*W + 4*k + 3];
        end
        chk("cap_P", fp, 3'b101);
        chk("cap_G", fg, 3'b010);
        chk("cap_S", fs, 3'b001);
        chk("cap_C", fc, 3'b110);
        v = '0;
        for (int i = 0; i < 4 * W; i++) v[i] = got[i];
        chk("cap_sel", v[4*W-1:0], 0);

        // Capture together with shift: shift is dropped
        cfg_capture = 1; cfg_en = 1; cfg_si = 1; cycle();
        idle();

        // Randomised traffic with interleaved config events
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a   = 9'($urandom);
            bus.b   = 9'($urandom);
            bus.cin = 3'($urandom);
            cfg_en      = 1'($urandom_range(0, 1));
            cfg_si      = 1'($urandom_range(0, 1));
            cfg_commit  = ($urandom_range(0, 7) == 0);
            cfg_capture = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle();
        bus.out_ready = 1;
        cycle();

        // Asynchronous reset mid-shift with a pending output
        beat(9'h1ff, 9'h1ff, 3'b111);
        bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cfg_en = 1; cfg_si = 1; cycle();
        end
        cfg_en = 0;
        #3;
        rst_n = 0;
        mreset();
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_sum", bus.sum, 0);
        chk("arst_cout", bus.cout, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_cfg_so", cfg_so, 0);
        #2;
        rst_n = 1;
        beat(9'b111_010_011, 9'b111_001_101, 3'b110);
        chk("post_rst_sum", bus.sum, 9'b111_100_000);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
